// File: rtl/pq_pop_reader.sv
// ============================================================================
// Module   : pq_pop_reader (with pq_pkg)
// Brief    : Credit-limited pop engine draining a priority queue into an
//            elastic output buffer on a valid/ready stream.
//            Optional macro PQ_READER_ORDER_CHECK_EN adds order_err_o/pop_cnt_o.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pq_pkg;
  localparam int QUEUE_DEPTH = 16;
  localparam int CNT_WIDTH   = $clog2(QUEUE_DEPTH);
  localparam int DATA_WIDTH  = 16;
  localparam int ID_WIDTH    = 8;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [ID_WIDTH-1:0]   id;
  } cell_t;
endpackage

module pq_pop_reader #(
  parameter int BUF_DEPTH   = 4,
  parameter int POP_LATENCY = 1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             enable_i,
  input  logic                             flush_i,
  input  logic [pq_pkg::CNT_WIDTH:0]       pq_cnt_i,
  output logic                             pq_pop_o,
  input  logic [$bits(pq_pkg::cell_t)-1:0] pq_cell_i,
  output logic                             m_valid_o,
  input  logic                             m_ready_i,
  output logic [$bits(pq_pkg::cell_t)-1:0] m_cell_o,
  output logic                             busy_o
`ifdef PQ_READER_ORDER_CHECK_EN
  ,
  output logic                             order_err_o,
  output logic [15:0]                      pop_cnt_o
`endif
);

  localparam int CELL_W = $bits(pq_pkg::cell_t);
  localparam int PTR_W  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int OCC_W  = $clog2(BUF_DEPTH + 1);
  localparam int SUM_W  = OCC_W + 4;

  generate
    if (BUF_DEPTH < POP_LATENCY + 1) begin : g_bad_depth
      $error("pq_pop_reader: BUF_DEPTH must be >= POP_LATENCY+1");
    end
    if (POP_LATENCY < 1 || POP_LATENCY > 4) begin : g_bad_latency
      $error("pq_pop_reader: POP_LATENCY must be in 1..4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [POP_LATENCY-1:0]   sr_q, sr_d;
  logic [POP_LATENCY:0]     sr_ext;
  logic [OCC_W-1:0]         occ_q, occ_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CELL_W-1:0]        mem_q [BUF_DEPTH];
  logic [CELL_W-1:0]        mem_d [BUF_DEPTH];
  logic                     pop_q, pop_d;
  logic                     busy_q, busy_d;

  logic [SUM_W-1:0]         inflight;
  logic                     resp;
  logic                     full;
  logic                     wr_en;
  logic                     rd_en;
  logic                     overflow;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i < POP_LATENCY; i++) begin
      inflight = inflight + SUM_W'(sr_q[i]);
    end

    // Count guard: a pop issued last cycle is not yet reflected in pq_cnt_i.
    pq_pop_o = !rst_i && (state_q == RUN) && enable_i && !flush_i
               && (pq_cnt_i > {{pq_pkg::CNT_WIDTH{1'b0}}, pop_q})
               && ((SUM_W'(occ_q) + inflight) < SUM_W'(BUF_DEPTH));

    resp     = sr_q[POP_LATENCY-1];
    rd_en    = (occ_q != '0) && m_ready_i;
    full     = (occ_q == OCC_W'(BUF_DEPTH));
    wr_en    = resp && (!full || rd_en);
    overflow = resp && full && !rd_en;

    sr_ext   = {sr_q, pq_pop_o};
    sr_d     = sr_ext[POP_LATENCY-1:0];
    pop_d    = pq_pop_o;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;

    if (wr_en) begin
      mem_d[wr_ptr_q] = pq_cell_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (rd_en) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({wr_en, rd_en})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase

    if (flush_i) begin
      sr_d     = '0;
      occ_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end

    busy_d = (occ_d != '0) || (sr_d != '0);

    state_d = state_q;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (enable_i) state_d = RUN;
        RUN:     if (!enable_i) state_d = STOP;
        STOP: begin
          if (enable_i)              state_d = RUN;
          else if (inflight == '0)   state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      occ_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      pop_q    <= 1'b0;
      busy_q   <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      occ_q    <= occ_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      pop_q    <= pop_d;
      busy_q   <= busy_d;
      mem_q    <= mem_d;
    end
  end

  assign m_valid_o = (occ_q != '0);
  assign m_cell_o  = mem_q[rd_ptr_q];
  assign busy_o    = busy_q;

  a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i) !overflow);

`ifdef PQ_READER_ORDER_CHECK_EN
  pq_pkg::cell_t                 cell_in;
  logic [pq_pkg::DATA_WIDTH-1:0] prev_data_q, prev_data_d;
  logic                          prev_vld_q, prev_vld_d;
  logic                          err_q, err_d;
  logic [15:0]                   pcnt_q, pcnt_d;

  assign cell_in = pq_cell_i;

  // The queue hands out non-increasing data; a rise means order was broken.
  always_comb begin
    prev_data_d = prev_data_q;
    prev_vld_d  = prev_vld_q;
    err_d       = err_q;
    pcnt_d      = pcnt_q;
    if (pq_pop_o && pcnt_q != 16'hFFFF) pcnt_d = pcnt_q + 16'd1;
    if (wr_en) begin
      if (prev_vld_q && (cell_in.data > prev_data_q)) err_d = 1'b1;
      prev_data_d = cell_in.data;
      prev_vld_d  = 1'b1;
    end
    if (pq_cnt_i == '0) prev_vld_d = 1'b0;
    if (flush_i) begin
      prev_vld_d = 1'b0;
      err_d      = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_data_q <= '0;
      prev_vld_q  <= 1'b0;
      err_q       <= 1'b0;
      pcnt_q      <= '0;
    end else begin
      prev_data_q <= prev_data_d;
      prev_vld_q  <= prev_vld_d;
      err_q       <= err_d;
      pcnt_q      <= pcnt_d;
    end
  end

  assign order_err_o = err_q;
  assign pop_cnt_o   = pcnt_q;
`endif

endmodule

`default_nettype wire
